// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register controller: register map,
// CTRL bit positions, frame length and sequencer states.
package spi_reg_pkg;

  localparam int unsigned FRAME_LEN = 16;

  localparam logic [3:0] ADDR_LED    = 4'd0;
  localparam logic [3:0] ADDR_CTRL   = 4'd1;
  localparam logic [3:0] ADDR_SAWDIV = 4'd2;
  localparam logic [3:0] ADDR_STATUS = 4'd3;
  localparam logic [3:0] ADDR_ID     = 4'd4;

  localparam int unsigned CTRL_SRC_SEL = 0;
  localparam int unsigned CTRL_PDM_EN  = 1;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StData
  } state_e;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// SPI pin bundle between the SAMD51 master and the register controller.
interface spi_reg_ctrl_if;
  logic spi_cs;
  logic spi_sck;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_cs, output spi_sck, output spi_mosi, input spi_miso);
  modport slave  (input spi_cs, input spi_sck, input spi_mosi, output spi_miso);
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus a third flop for edge detect.
module sync_edge (
  input  logic clk,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // No reset: the chain settles to the pin level, so a reset never fakes an edge.
  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    sync_q <= {sync_q[1:0], din};
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI slave sequencer: 16-bit header then burst 16-bit data frames, driving the
// LED/CTRL/saw-divider registers and returning status/ID on reads.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter logic [15:0] ID_VALUE    = 16'hD0B1,
  parameter logic [15:0] SAW_DIV_RST = 16'd25000,
  parameter logic [15:0] LED_RST     = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  spi_reg_ctrl_if.slave spi,
  input  logic [15:0]   status_in,
  output logic [15:0]   led_data,
  output logic          src_sel,
  output logic          pdm_en,
  output logic [15:0]   saw_div,
  output logic          wr_stb,
  output logic [3:0]    wr_addr
);

  logic cs_lvl, cs_rise, cs_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync;

  sync_edge u_sync_cs (
    .clk  (clk),
    .din  (spi.spi_cs),
    .level(cs_lvl),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  sync_edge u_sync_sck (
    .clk  (clk),
    .din  (spi.spi_sck),
    .level(sck_lvl),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  sync_edge u_sync_mosi (
    .clk  (clk),
    .din  (spi.spi_mosi),
    .level(mosi_lvl),
    .rise (mosi_rise),
    .fall (mosi_fall)
  );

  assign unused_sync = ^{cs_lvl, sck_lvl, mosi_rise, mosi_fall};

  state_e      st_q;
  logic [15:0] shift_q;
  logic [15:0] miso_q;
  logic [3:0]  bit_cnt_q;
  logic [3:0]  addr_q;
  logic        wr_q;
  logic        skip_q;
  logic        done_q;  // a full frame landed in shift_q last cycle

  logic [3:0]  rd_addr;
  logic [15:0] rd_data;

  // Header frame reads its own address; data frames prefetch the next one.
  always_comb begin
    rd_addr = (st_q == StHdr) ? shift_q[3:0] : addr_q + 4'd1;
    case (rd_addr)
      ADDR_LED:    rd_data = led_data;
      ADDR_CTRL:   rd_data = {14'b0, pdm_en, src_sel};
      ADDR_SAWDIV: rd_data = saw_div;
      ADDR_STATUS: rd_data = status_in;
      ADDR_ID:     rd_data = ID_VALUE;
      default:     rd_data = 16'h0000;
    endcase
  end

  assign spi.spi_miso = miso_q[15];

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= StIdle;
      shift_q   <= '0;
      miso_q    <= '0;
      bit_cnt_q <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      skip_q    <= 1'b0;
      done_q    <= 1'b0;
      led_data  <= LED_RST;
      src_sel   <= 1'b0;
      pdm_en    <= 1'b0;
      saw_div   <= SAW_DIV_RST;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
    end else begin
      wr_stb <= 1'b0;
      done_q <= 1'b0;

      case (st_q)
        StIdle: begin
          if (cs_fall) begin
            st_q      <= StHdr;
            bit_cnt_q <= '0;
            miso_q    <= '0;
          end
        end
        StHdr, StData: begin
          if (sck_rise) begin
            shift_q   <= {shift_q[14:0], mosi_lvl};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'(FRAME_LEN - 1)) begin
              done_q <= 1'b1;
            end
          end
          if (sck_fall && st_q == StData) begin
            if (skip_q) begin
              skip_q <= 1'b0;
            end else begin
              miso_q <= {miso_q[14:0], 1'b0};
            end
          end
        end
        default: st_q <= StIdle;
      endcase

      if (done_q) begin
        if (st_q == StHdr) begin
          wr_q   <= shift_q[15];
          addr_q <= shift_q[3:0];
          st_q   <= StData;
          if (!shift_q[15]) begin
            miso_q <= rd_data;
            skip_q <= 1'b1;
          end
        end else if (st_q == StData) begin
          if (wr_q && addr_q <= ADDR_SAWDIV) begin
            wr_stb  <= 1'b1;
            wr_addr <= addr_q;
            case (addr_q)
              ADDR_LED:  led_data <= shift_q;
              ADDR_CTRL: begin
                src_sel <= shift_q[CTRL_SRC_SEL];
                pdm_en  <= shift_q[CTRL_PDM_EN];
              end
              default:   saw_div <= shift_q;
            endcase
          end
          addr_q <= addr_q + 4'd1;
          if (!wr_q) begin
            miso_q <= rd_data;
            skip_q <= 1'b1;
          end
        end
      end

      // cs rise beats everything else; a completed frame's commit above still lands.
      if (cs_rise) begin
        st_q      <= StIdle;
        done_q    <= 1'b0;
        miso_q    <= '0;
        skip_q    <= 1'b0;
        bit_cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed scenarios plus random bursts against a
// register-map model.
module tb_spi_reg_ctrl;
  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] status_in = '0;
  logic [15:0] led_data, saw_div;
  logic        src_sel, pdm_en, wr_stb;
  logic [3:0]  wr_addr;

  spi_reg_ctrl_if spi ();

  spi_reg_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .spi      (spi),
    .status_in(status_in),
    .led_data (led_data),
    .src_sel  (src_sel),
    .pdm_en   (pdm_en),
    .saw_div  (saw_div),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_led, m_saw;
  logic [1:0]  m_ctrl;
  int          exp_wr[$];
  int          got_wr[$];

  always @(negedge clk) if (wr_stb) got_wr.push_back(int'(wr_addr));

  function automatic logic [15:0] model_read(input int a);
    case (a)
      0: return m_led;
      1: return {14'b0, m_ctrl};
      2: return m_saw;
      3: return status_in;
      4: return 16'hD0B1;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_write(input int a, input logic [15:0] d);
    if (a == 0) m_led = d;
    if (a == 1) m_ctrl = d[1:0];
    if (a == 2) m_saw = d;
    if (a <= 2) exp_wr.push_back(a);
  endtask

  task automatic model_reset();
    m_led = 16'h0000;
    m_ctrl = 2'b00;
    m_saw = 16'd25000;
  endtask

  task automatic cs_low();
    spi.spi_cs = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    spi.spi_cs = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  // Mode 0 master: drive mosi while sck low, sample miso just before the rise.
  task automatic spi_bits(input logic [15:0] tx, input int n, output logic [15:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      spi.spi_mosi = tx[15-i];
      repeat (HALF) @(negedge clk);
      rx = {rx[14:0], spi.spi_miso};
      spi.spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      spi.spi_sck = 1'b0;
    end
  endtask

  task automatic check_regs(input string tag);
    n_checks++;
    if (led_data !== m_led) begin
      n_errors++;
      $display("FAIL %s led_data: got %h expected %h", tag, led_data, m_led);
    end
    n_checks++;
    if ({pdm_en, src_sel} !== m_ctrl) begin
      n_errors++;
      $display("FAIL %s ctrl: got %b expected %b", tag, {pdm_en, src_sel}, m_ctrl);
    end
    n_checks++;
    if (saw_div !== m_saw) begin
      n_errors++;
      $display("FAIL %s saw_div: got %0d expected %0d", tag, saw_div, m_saw);
    end
  endtask

  task automatic check_wr(input string tag);
    n_checks++;
    if (got_wr.size() != exp_wr.size()) begin
      n_errors++;
      $display("FAIL %s wr_stb count: got %0d expected %0d", tag, got_wr.size(),
               exp_wr.size());
    end else begin
      foreach (exp_wr[i]) begin
        n_checks++;
        if (got_wr[i] != exp_wr[i]) begin
          n_errors++;
          $display("FAIL %s wr_addr[%0d]: got %0d expected %0d", tag, i, got_wr[i], exp_wr[i]);
        end
      end
    end
    got_wr.delete();
    exp_wr.delete();
  endtask

  task automatic check_idle(input string tag);
    n_checks++;
    if (spi.spi_miso !== 1'b0 || wr_stb !== 1'b0) begin
      n_errors++;
      $display("FAIL %s idle miso/wr_stb: got %b/%b expected 0/0", tag, spi.spi_miso, wr_stb);
    end
  endtask

  task automatic test_reset();
    model_reset();
    check_regs("reset");
    check_idle("reset");
    n_checks++;
    if (wr_addr !== 4'd0) begin
      n_errors++;
      $display("FAIL reset wr_addr: got %0d expected 0", wr_addr);
    end
  endtask

  task automatic test_write_led();
    logic [15:0] rx;
    cs_low();
    spi_bits(16'h8000, 16, rx);
    spi_bits(16'h0017, 16, rx);
    model_write(0, 16'h0017);
    cs_high();
    check_regs("write_led");
    check_wr("write_led");
  endtask

  task automatic test_status_read();
    logic [15:0] rx;
    status_in = 16'h53F0;
    cs_low();
    spi_bits(16'h0003, 16, rx);
    spi_bits(16'h0000, 16, rx);
    cs_high();
    n_checks++;
    if (rx !== 16'h53F0) begin
      n_errors++;
      $display("FAIL status_read data: got %h expected 53f0", rx);
    end
    check_regs("status_read");
    check_wr("status_read");
  endtask

  task automatic test_burst_write();
    logic [15:0] rx;
    cs_low();
    spi_bits(16'h8001, 16, rx);
    spi_bits(16'h0003, 16, rx);
    spi_bits(16'h1234, 16, rx);
    model_write(1, 16'h0003);
    model_write(2, 16'h1234);
    cs_high();
    check_regs("burst_write");
    check_wr("burst_write");
  endtask

  task automatic test_abort();
    logic [15:0] rx;
    cs_low();
    spi_bits(16'h8000, 16, rx);
    spi_bits(16'hFFFF, 9, rx);
    cs_high();
    check_regs("abort");
    check_wr("abort");
    check_idle("abort");
    // A fresh transaction after the abort must decode cleanly.
    cs_low();
    spi_bits(16'h0000, 16, rx);
    spi_bits(16'h0000, 16, rx);
    cs_high();
    n_checks++;
    if (rx !== m_led) begin
      n_errors++;
      $display("FAIL abort readback: got %h expected %h", rx, m_led);
    end
  endtask

  task automatic test_id_burst();
    logic [15:0] rx0, rx1;
    cs_low();
    spi_bits(16'h0004, 16, rx0);
    spi_bits(16'h0000, 16, rx0);
    spi_bits(16'h0000, 16, rx1);
    cs_high();
    n_checks++;
    if (rx0 !== 16'hD0B1 || rx1 !== 16'h0000) begin
      n_errors++;
      $display("FAIL id_burst: got %h %h expected d0b1 0000", rx0, rx1);
    end
    cs_low();
    spi_bits(16'h8004, 16, rx0);
    spi_bits(16'h0000, 16, rx0);
    cs_high();
    check_wr("id_write");
    cs_low();
    spi_bits(16'h0004, 16, rx0);
    spi_bits(16'h0000, 16, rx0);
    cs_high();
    n_checks++;
    if (rx0 !== 16'hD0B1) begin
      n_errors++;
      $display("FAIL id_after_write: got %h expected d0b1", rx0);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rx;
    cs_low();
    spi_bits(16'h8000, 16, rx);
    spi_bits(16'h00AA, 16, rx);
    model_write(0, 16'h00AA);
    cs_high();
    check_regs("pre_reset");
    check_wr("pre_reset");
    cs_low();
    spi_bits(16'h8000, 8, rx);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_regs("reset_mid");
    check_idle("reset_mid");
    spi_bits(16'h00FF, 8, rx);
    cs_high();
    check_regs("reset_mid_tail");
    check_wr("reset_mid_tail");
    cs_low();
    spi_bits(16'h8000, 16, rx);
    spi_bits(16'h5A5A, 16, rx);
    model_write(0, 16'h5A5A);
    cs_high();
    check_regs("post_reset");
    check_wr("post_reset");
  endtask

  task automatic test_random();
    logic [15:0] rx, d, e;
    int w, a, len, ad;
    for (int it = 0; it < 24; it++) begin
      w = int'($urandom_range(0, 1));
      a = int'($urandom_range(0, 7));
      len = int'($urandom_range(1, 3));
      status_in = 16'($urandom);
      cs_low();
      spi_bits({w[0], 11'b0, a[3:0]}, 16, rx);
      for (int k = 0; k < len; k++) begin
        ad = (a + k) % 16;
        d = 16'($urandom);
        if (w == 1) begin
          spi_bits(d, 16, rx);
          model_write(ad, d);
        end else begin
          e = model_read(ad);
          spi_bits(d, 16, rx);
          n_checks++;
          if (rx !== e) begin
            n_errors++;
            $display("FAIL random read it%0d addr %0d: got %h expected %h", it, ad, rx, e);
          end
        end
      end
      cs_high();
      check_regs("random");
      check_wr("random");
    end
  endtask

  initial begin
    spi.spi_cs = 1'b1;
    spi.spi_sck = 1'b0;
    spi.spi_mosi = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    test_reset();
    test_write_led();
    test_status_read();
    test_burst_write();
    test_abort();
    test_id_burst();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- SPI slave command sequencer and register file that configures the LED/waveform datapath from the SAMD51 over cfg_cs/cfg_si/cfg_sck/cfg_so.
- Resynchronises the raw SPI pins into clk and decodes header and data frames.
- Owns the configuration registers: LED word, source select, PDM enable, saw divider. Returns status pins and an ID on reads.
- Sits between the top-level SPI pins and the LED16/saw/pdm instances. It replaces the ad-hoc shifter currently in top.

Parameters:
- ID_VALUE, 16'hD0B1, constant returned at address 4.
- SAW_DIV_RST, 16'd25000, reset value of the saw divider register.
- LED_RST, 16'h0000, reset value of the LED data register.

Ports:
- clk  in  1  48 MHz SB_HFOSC clock.
- rst  in  1  synchronous reset, active-high.
- spi_cs  in  1  raw chip select, active-low, asynchronous.
- spi_sck  in  1  raw SPI clock, mode 0, asynchronous.
- spi_mosi  in  1  raw serial data in, asynchronous.
- spi_miso  out  1  serial data out, MSB first.
- status_in  in  16  pin state snapshot, returned at address 3.
- led_data  out  16  register 0, drives LED16 ledbits.
- src_sel  out  1  CTRL[0]: 0 = led_data shown, 1 = PDM output shown.
- pdm_en  out  1  CTRL[1]: 0 holds pdm in reset.
- saw_div  out  16  register 2, saw clock divider.
- wr_stb  out  1  one-cycle pulse on every accepted register write.
- wr_addr  out  4  address of the write flagged by wr_stb.

Behaviour:
- Reset values: led_data = LED_RST, src_sel = 0, pdm_en = 0, saw_div = SAW_DIV_RST, spi_miso = 0, wr_stb = 0, wr_addr = 0, FSM = IDLE.
- Reset mid-transaction aborts the transaction. The next transaction begins only at a fresh cs falling edge.
- Synchronisers: spi_cs, spi_sck and spi_mosi each pass through 2 flops. A third flop per signal provides edge detect.
  - Events are recognised 3 clk after the pin transition.
  - The master's sck half-period must be ≥ 4 clk (sck ≤ 6 MHz).
- Sampling: mosi is sampled on the detected sck rising edge. miso changes on the detected sck falling edge.
- FSM:
  - IDLE: go to HDR on cs falling edge; clear bit_cnt.
  - HDR: shift 16 bits in. After the 16th rising edge, latch header = {W[15], rsvd[14:4], addr[3:0]} and go to DATA.
    - For a read (W = 0), load miso_shift with the read data of addr in the cycle after the 16th rise, and set skip = 1.
  - DATA: shift 16 bits in. After the 16th rising edge:
    - If W = 1 and addr is writable, commit the word in the next cycle, with wr_stb = 1 and wr_addr = addr.
    - addr increments mod 16, and the FSM stays in DATA (burst).
    - For reads, miso_shift is reloaded from the new addr and skip is set.
  - cs rising edge in any state: return to IDLE. Discard partial frames; no write occurs.
- MISO:
  - spi_miso = miso_shift[15].
  - On a detected falling edge: if skip = 1, clear skip and do not shift. Otherwise shift left, filling with 0.
  - In HDR and IDLE, miso_shift = 0.
- Register map:
  - 0 LED RW.
  - 1 CTRL RW; bits [1:0] are used, upper bits read 0.
  - 2 SAW_DIV RW.
  - 3 STATUS RO; status_in is sampled at load time.
  - 4 ID RO.
  - 5..15 read 0.
  - Writes to 3..15 are ignored with no wr_stb.
- Simultaneous cs rise and sck rise in the same cycle: cs wins and the bit is dropped.
- Any cs rise returns the FSM to IDLE. A cs fall in the same cycle as a pending commit is lost; a new transaction needs a fresh cs fall.

Decomposition:
- Shared package spi_reg_pkg:
  - Address constants ADDR_LED = 0, ADDR_CTRL = 1, ADDR_SAWDIV = 2, ADDR_STATUS = 3, ADDR_ID = 4.
  - CTRL bit indices.
  - FSM state encoding IDLE/HDR/DATA.
  - Frame length 16.
- One sub-module: sync_edge, a 2-flop synchroniser plus edge detect with outputs level, rise, fall. It is instantiated three times.

Test Plan:
- Write 16'h0017 to addr 0 (header 16'h8000): led_data = 16'h0017 one clk after the last sck rise is detected; wr_stb pulses once with wr_addr = 0.
- Set status_in = 16'h53F0, then read addr 3 (header 16'h0003): miso bits on the 16 data-frame rises equal 16'h53F0 MSB-first; led_data is unchanged.
- Burst write header 16'h8001, then data 16'h0003, 16'h1234: src_sel = 1, pdm_en = 1, saw_div = 16'h1234; 2 wr_stb pulses (addr 1, then 2).
- Deassert cs after 9 data bits of a write to addr 0 with data 16'hFFFF: led_data keeps its old value, no wr_stb, FSM = IDLE.
- Burst read starting at addr 4: returns ID_VALUE, then 0 for addr 5. Write to addr 4 with 16'h0000: ID still reads 16'hD0B1, no wr_stb.
- Assert rst mid-header after a prior write of 16'h00AA to addr 0: all outputs return to reset values (led_data = 0, saw_div = 25000); the following clean transaction decodes correctly.
